// File: rtl/alu_md.sv
// alu_md : EX-stage ALU with registered outputs, valid/ready issue handshake,
//          set/shift ops and an iterative multiply/divide unit with HI/LO.
//
// Build option: define ALU_FAST_MUL_EN to use a single-cycle combinational
// multiplier for mult/multu. Divides stay iterative either way.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   op issue request
//   in_ready   unit can accept an op (FSM in IDLE)
//   ctl[4:0]   operation select
//   a, b       operands
//   flush      abort any op in flight / suppress accept in IDLE
//   out_valid  one-cycle result pulse
//   out        registered result
//   zero       registered (a==b) of the accepted single-cycle op
//   overflow   registered signed overflow for add/sub
//   busy       mult/div in progress
//
// FSM
//   state  | meaning
//   IDLE   | ready to accept; single-cycle ops complete here
//   BUSY   | one mul/div step per cycle, counter WIDTH-1 down to 0
//   FIX    | sign correction, HI/LO write, result pulse

module alu_md #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       ctl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic             busy
);

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_LUI  = 5'd5;
   localparam logic [4:0] OP_NOR  = 5'd6;
   localparam logic [4:0] OP_SLT  = 5'd7;
   localparam logic [4:0] OP_SLTU = 5'd8;
   localparam logic [4:0] OP_SLL  = 5'd9;
   localparam logic [4:0] OP_SRL  = 5'd10;
   localparam logic [4:0] OP_SRA  = 5'd11;
   localparam logic [4:0] OP_MFHI = 5'd16;
   localparam logic [4:0] OP_MFLO = 5'd17;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   hi, lo;
   logic [2*WIDTH-1:0] prod;      // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   opa;       // original dividend, needed for divide-by-zero HI
   logic               md_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               div0;

   // ctl 12..15 are the multi-cycle ops; bit1 selects div, bit0 selects unsigned
   logic is_md, md_signed, accept;
   assign is_md     = (ctl[4:2] == 3'b011);
   assign md_signed = ~ctl[0];
   assign accept    = in_valid && in_ready && !flush;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && is_md) begin
`ifdef ALU_FAST_MUL_EN
               state_d = ctl[1] ? S_BUSY : S_FIX;
`else
               state_d = S_BUSY;
`endif
            end
         end
         S_BUSY: begin
            if (flush)           state_d = S_IDLE;
            else if (cnt == '0)  state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = 1'b1;
         S_BUSY:  busy     = 1'b1;
         S_FIX:   busy     = 1'b1;
         default: busy     = 1'b0;
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   logic [WIDTH-1:0] sum, diff, res;
   logic [SHW-1:0]   sh;
   logic             ovf;

   assign sum  = a + b;
   assign diff = a - b;
   assign sh   = a[SHW-1:0];

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (ctl)
         OP_ADD: begin
            res = sum;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res = diff;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_LUI:  res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_NOR:  res = ~(a | b);
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  res = b << sh;
         OP_SRL:  res = b >> sh;
         OP_SRA:  res = $signed(b) >>> sh;
         OP_MFHI: res = hi;
         OP_MFLO: res = lo;
         default: res = '0;
      endcase
   end

   // ---------------- mul/div step logic ----------------
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_next;
   logic [WIDTH:0]     rem_sh, rem_trial;
   logic               rem_ge;

   assign mag_a = (md_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b = (md_signed && b[WIDTH-1]) ? -b : b;

   // Right-shifting shift-add: the multiplier drains out of the low half
   // while the product fills in from the top.
   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opb : '0)};
   assign mul_next = {mul_sum, prod[WIDTH-1:1]};

   // Restoring divide: shift next dividend bit into the remainder, keep the
   // subtraction only when it does not go negative.
   assign rem_sh    = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
   assign rem_ge    = (rem_sh >= {1'b0, opb});
   assign rem_trial = rem_sh - {1'b0, opb};
   assign div_next  = {(rem_ge ? rem_trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       prod[WIDTH-2:0], rem_ge};

`ifdef ALU_FAST_MUL_EN
   logic               is_mul;
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign is_mul    = is_md && !ctl[1];
   // Low 2*WIDTH bits of the product of sign/zero-extended operands equal
   // the exact signed/unsigned product.
   assign ext_a     = md_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign ext_b     = md_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign fast_prod = ext_a * ext_b;
`endif

   // ---------------- FIX: sign correction ----------------
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod_neg;
   assign prod_neg = -prod;

   always_comb begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (md_div) begin
         if (div0) begin
            fix_lo = '1;
            fix_hi = opa;
         end else begin
            fix_lo = neg_lo ? -prod[WIDTH-1:0]       : prod[WIDTH-1:0];
            fix_hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
         end
      end else if (neg_lo) begin
         fix_hi = prod_neg[2*WIDTH-1:WIDTH];
         fix_lo = prod_neg[WIDTH-1:0];
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         prod      <= '0;
         opb       <= '0;
         opa       <= '0;
         md_div    <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         div0      <= 1'b0;
         out       <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept && is_md) begin
                  cnt    <= SHW'(WIDTH-1);
                  prod   <= {{WIDTH{1'b0}}, mag_a};
                  opb    <= mag_b;
                  opa    <= a;
                  md_div <= ctl[1];
                  neg_lo <= md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi <= md_signed && a[WIDTH-1];
                  div0   <= (b == '0);
`ifdef ALU_FAST_MUL_EN
                  if (is_mul) begin
                     prod   <= fast_prod;
                     neg_lo <= 1'b0;
                  end
`endif
               end else if (accept) begin
                  out       <= res;
                  zero      <= (a == b);
                  overflow  <= ovf;
                  out_valid <= 1'b1;
               end
            end
            S_BUSY: begin
               if (!flush) begin
                  prod <= md_div ? div_next : mul_next;
                  cnt  <= cnt - SHW'(1);
               end
            end
            S_FIX: begin
               if (!flush) begin
                  hi        <= fix_hi;
                  lo        <= fix_lo;
                  out       <= fix_lo;
                  zero      <= 1'b0;
                  overflow  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
   localparam int W = 32;

`ifdef ALU_FAST_MUL_EN
   localparam int MUL_LOW = 1;
`else
   localparam int MUL_LOW = W + 1;
`endif

   logic         clk, rst_n, in_valid, flush;
   logic [4:0]   ctl;
   logic [W-1:0] a, b, out;
   logic         in_ready, out_valid, zero, overflow, busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] q_out[$];
   logic [1:0]   q_flg[$];
   string        q_name[$];

   alu_md #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ctl(ctl), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out(out), .zero(zero), .overflow(overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one op; when a result is expected it is queued for the monitor.
   task automatic issue(input string name, input logic [4:0] c, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] eo, input logic ez,
                        input logic eov, input bit want);
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) chk({name, " ready timeout"}, W'(in_ready), 1);
      ctl = c; a = va; b = vb; in_valid = 1'b1;
      if (want) begin
         q_out.push_back(eo);
         q_flg.push_back({ez, eov});
         q_name.push_back(name);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Monitor: every out_valid pops one expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (q_out.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected out_valid: out=%h, expected no result", out);
            end else begin
               string nm;
               logic [W-1:0] eo;
               logic [1:0] ef;
               nm = q_name.pop_front();
               eo = q_out.pop_front();
               ef = q_flg.pop_front();
               chk({nm, " out"}, out, eo);
               chk({nm, " zero/ovf"}, W'({zero, overflow}), W'(ef));
            end
         end
      end
   end

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ctl = '0; a = '0; b = '0;
      #3;
      chk("reset out_valid", W'(out_valid), 0);
      chk("reset busy", W'(busy), 0);
      chk("reset out", out, 0);
      chk("reset zero/ovf", W'({zero, overflow}), 0);
      #9 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after reset", W'(in_ready), 1);

      // single-cycle ops, back to back
      issue("add ovf",  5'd0,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b1, 1);
      issue("slt",      5'd7,  32'hFFFF_FFFF, 32'h0,          32'h1,         1'b0, 1'b0, 1);
      issue("sltu",     5'd8,  32'hFFFF_FFFF, 32'h0,          32'h0,         1'b0, 1'b0, 1);
      issue("sra",      5'd11, 32'h4,         32'h8000_0000,  32'hF800_0000, 1'b0, 1'b0, 1);
      issue("sub zero", 5'd1,  32'h5,         32'h5,          32'h0,         1'b1, 1'b0, 1);
      issue("sub ovf",  5'd1,  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      issue("and",      5'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'h00F0_00F0, 1'b0, 1'b0, 1);
      issue("or",       5'd3,  32'h1234_0000, 32'h0000_5678,  32'h1234_5678, 1'b0, 1'b0, 1);
      issue("xor",      5'd4,  32'hFFFF_0000, 32'h0F0F_0F0F,  32'hF0F0_0F0F, 1'b0, 1'b0, 1);
      issue("lui",      5'd5,  32'h0,         32'h1234_ABCD,  32'hABCD_0000, 1'b0, 1'b0, 1);
      issue("nor",      5'd6,  32'h0,         32'h0,          32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      issue("sll",      5'd9,  32'd36,        32'h3,          32'h30,        1'b0, 1'b0, 1);
      issue("srl",      5'd10, 32'd31,        32'h8000_0000,  32'h1,         1'b0, 1'b0, 1);
      issue("bad ctl",  5'd20, 32'h1,         32'h2,          32'h0,         1'b0, 1'b0, 1);

      // flush in IDLE suppresses the accept; the pending result still completes
      @(negedge clk);
      ctl = 5'd0; a = 32'h1; b = 32'h1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idle flush no out_valid", W'(out_valid), 0);

      // signed multiply, latency and HI
      issue("mult", 5'd12, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 1'b0, 1'b0, 1);
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         if (in_ready) break;
         cyc++;
      end
      chk("mult in_ready low cycles", W'(cyc), W'(MUL_LOW));
      chk("mult out_valid with ready", W'(out_valid), 1);
      issue("mfhi after mult", 5'd16, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);

      issue("div",        5'd14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 1'b0, 1);
      issue("mfhi div",   5'd16, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      issue("divu by 0",  5'd15, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      issue("mfhi div0",  5'd16, 32'h0,         32'h0,         32'h5,         1'b1, 1'b0, 1);
      issue("div min/-1", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
      issue("mfhi min",   5'd16, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 1);
      issue("divu",       5'd15, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1);
      issue("mfhi divu",  5'd16, 32'h0,         32'h0,         32'd2,         1'b1, 1'b0, 1);

      // flush mid-multiply: no result, HI/LO untouched
      issue("multu flushed", 5'd13, 32'd5, 32'd6, 32'h0, 1'b0, 1'b0, 0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush in_ready", W'(in_ready), 1);
      chk("flush busy", W'(busy), 0);
      issue("mflo after flush", 5'd17, 32'h0, 32'h0, 32'd14, 1'b1, 1'b0, 1);
      issue("mfhi after flush", 5'd16, 32'h0, 32'h0, 32'd2,  1'b1, 1'b0, 1);

      // asynchronous reset in the middle of a divide
      issue("div reset", 5'd14, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0, 0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", W'(out_valid), 0);
      chk("async rst busy", W'(busy), 0);
      #4 rst_n = 1'b1;
      @(negedge clk);
      chk("ready after rst", W'(in_ready), 1);
      ctl = 5'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
      q_out.push_back(32'd3); q_flg.push_back(2'b00); q_name.push_back("add after rst");
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("add after rst accepted", W'(out_valid), 1);
      issue("mfhi after rst", 5'd16, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
      issue("mflo after rst", 5'd17, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1);

      repeat (5) @(negedge clk);
      chk("scoreboard drained", W'(q_out.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
